// File: rtl/iss_sequencer_pkg.sv
// Shared types and decode helpers for the ISS sequencer.
//   top_level_types : EncType, InstrType, ALUfuncType, ME_MaskType
//   iss_types       : Phases, opcodes, decode / ALU / branch helpers
// No ports; imported by iss_sequencer_if, iss_execute_unit and iss_sequencer.

package top_level_types;
    typedef enum logic [3:0] {
        enc_r, enc_i_i, enc_i_l, enc_i_j, enc_s, enc_b, enc_u, enc_j, enc_err
    } EncType;

    typedef enum logic [3:0] {
        it_alu_r, it_alu_i, it_load, it_store, it_branch,
        it_lui, it_auipc, it_jal, it_jalr, instr_unknown
    } InstrType;

    typedef enum logic [3:0] {
        alu_add, alu_sub, alu_sll, alu_slt, alu_sltu,
        alu_xor, alu_srl, alu_sra, alu_or, alu_and
    } ALUfuncType;

    typedef enum logic [2:0] {mt_x, mt_b, mt_h, mt_w, mt_bu, mt_hu} ME_MaskType;
endpackage

package iss_types;
    import top_level_types::*;

    typedef enum logic [1:0] {fetch_ph, execute_ph, mem_req_ph, mem_done_ph} Phases;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    function automatic InstrType get_instr_type(input logic [31:0] instr);
        InstrType   t;
        logic [2:0] f3;
        logic       f7_ok;
        f3 = instr[14:12];
        // funct7 = 0100000 is only meaningful for sub / sra / srai
        f7_ok = (instr[31:25] == 7'b0000000) ||
                (instr[31:25] == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
        t = instr_unknown;
        case (instr[6:0])
            OP_R:      if (f7_ok) t = it_alu_r;
            OP_I:      if ((f3 != 3'b001 && f3 != 3'b101) || f7_ok) t = it_alu_i;
            OP_LOAD:   if (f3 != 3'b011 && f3 < 3'b110) t = it_load;
            OP_STORE:  if (f3 < 3'b011) t = it_store;
            OP_BRANCH: if (f3 != 3'b010 && f3 != 3'b011) t = it_branch;
            OP_LUI:    t = it_lui;
            OP_AUIPC:  t = it_auipc;
            OP_JAL:    t = it_jal;
            OP_JALR:   if (f3 == 3'b000) t = it_jalr;
            default:   t = instr_unknown;
        endcase
        return t;
    endfunction

    function automatic EncType get_enc_type(input logic [31:0] instr);
        case (get_instr_type(instr))
            it_alu_r:          return enc_r;
            it_alu_i:          return enc_i_i;
            it_load:           return enc_i_l;
            it_store:          return enc_s;
            it_branch:         return enc_b;
            it_lui, it_auipc:  return enc_u;
            it_jal:            return enc_j;
            it_jalr:           return enc_i_j;
            default:           return enc_err;
        endcase
    endfunction

    // Branches reuse the ALU: sub for eq/ne, slt / sltu for the ordered compares.
    function automatic ALUfuncType get_alu_funct(input logic [31:0] instr);
        logic [2:0] f3;
        f3 = instr[14:12];
        if (instr[6:0] == OP_BRANCH) begin
            case (f3[2:1])
                2'b00:   return alu_sub;
                2'b10:   return alu_slt;
                default: return alu_sltu;
            endcase
        end
        case (f3)
            3'b000:  return (instr[6:0] == OP_R && instr[30]) ? alu_sub : alu_add;
            3'b001:  return alu_sll;
            3'b010:  return alu_slt;
            3'b011:  return alu_sltu;
            3'b100:  return alu_xor;
            3'b101:  return instr[30] ? alu_sra : alu_srl;
            3'b110:  return alu_or;
            default: return alu_and;
        endcase
    endfunction

    function automatic logic [31:0] get_alu_result(input ALUfuncType fn,
                                                   input logic [31:0] a,
                                                   input logic [31:0] b);
        case (fn)
            alu_sub:  return a - b;
            alu_sll:  return a << b[4:0];
            alu_slt:  return {31'b0, $signed(a) < $signed(b)};
            alu_sltu: return {31'b0, a < b};
            alu_xor:  return a ^ b;
            alu_srl:  return a >> b[4:0];
            alu_sra:  return $unsigned($signed(a) >>> b[4:0]);
            alu_or:   return a | b;
            alu_and:  return a & b;
            default:  return a + b;
        endcase
    endfunction

    function automatic logic [31:0] get_immediate(input logic [31:0] i, input EncType enc);
        case (enc)
            enc_i_i, enc_i_l, enc_i_j: return {{20{i[31]}}, i[31:20]};
            enc_s:   return {{20{i[31]}}, i[31:25], i[11:7]};
            enc_b:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            enc_u:   return {i[31:12], 12'b0};
            enc_j:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic ME_MaskType get_memory_mask(input logic [31:0] instr);
        case (instr[14:12])
            3'b000:  return mt_b;
            3'b001:  return mt_h;
            3'b010:  return mt_w;
            3'b100:  return mt_bu;
            3'b101:  return mt_hu;
            default: return mt_x;
        endcase
    endfunction

    // funct3[0] inverts the base condition (bne / bge / bgeu).
    function automatic logic [31:0] branch_PC_calculation(input logic [31:0] instr,
                                                          input logic [31:0] alu_res,
                                                          input logic [31:0] pc);
        logic taken;
        taken = (instr[14:13] == 2'b00) ? (alu_res == 32'h0) : alu_res[0];
        taken = taken ^ instr[12];
        return taken ? pc + get_immediate(instr, enc_b) : pc + 32'd4;
    endfunction

    // Opcode bit 5 separates lui (1) from auipc (0).
    function automatic logic [31:0] get_Enc_U_ALU_result(input logic [31:0] instr,
                                                         input logic [31:0] pc);
        return instr[5] ? get_immediate(instr, enc_u) : pc + get_immediate(instr, enc_u);
    endfunction
endpackage

// File: rtl/iss_sequencer_if.sv
// Instruction- and data-memory handshake bundle.
//   master : sequencer side (drives requests, receives ready / responses)
//   slave  : memory side

interface iss_sequencer_if;
    import top_level_types::*;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_instr;

    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_data;
    logic        dmem_req_wr;
    ME_MaskType  dmem_req_mask;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_instr,
        output dmem_req_valid, dmem_req_addr, dmem_req_data, dmem_req_wr, dmem_req_mask,
        input  dmem_req_ready, dmem_resp_valid, dmem_resp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_instr,
        input  dmem_req_valid, dmem_req_addr, dmem_req_data, dmem_req_wr, dmem_req_mask,
        output dmem_req_ready, dmem_resp_valid, dmem_resp_data
    );
endinterface

// File: rtl/iss_execute_unit.sv
// Combinational execute stage for one instruction.
//   in : instr, pc, rs1, rs2
//   out: next_pc, rd_value/rd_write, mem_addr/mem_data/mem_wr/mem_mask, is_mem, illegal

module iss_execute_unit
    import top_level_types::*;
    import iss_types::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] next_pc,
    output logic [31:0] rd_value,
    output logic        rd_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_wr,
    output ME_MaskType  mem_mask,
    output logic        is_mem,
    output logic        illegal
);
    EncType      enc;
    ALUfuncType  fn;
    logic [31:0] imm;
    logic [31:0] pc_plus4;
    logic [31:0] base_sum;

    assign enc      = get_enc_type(instr);
    assign fn       = get_alu_funct(instr);
    assign imm      = get_immediate(instr, enc);
    assign pc_plus4 = pc + 32'd4;
    assign base_sum = rs1 + imm;

    always_comb begin
        next_pc  = pc_plus4;
        rd_value = 32'h0;
        rd_write = 1'b0;
        mem_addr = base_sum;
        mem_data = rs2;
        mem_wr   = 1'b0;
        mem_mask = get_memory_mask(instr);
        is_mem   = 1'b0;
        illegal  = 1'b0;
        case (enc)
            enc_r: begin
                rd_value = get_alu_result(fn, rs1, rs2);
                rd_write = 1'b1;
            end
            enc_i_i: begin
                rd_value = get_alu_result(fn, rs1, imm);
                rd_write = 1'b1;
            end
            enc_u: begin
                rd_value = get_Enc_U_ALU_result(instr, pc);
                rd_write = 1'b1;
            end
            enc_b: next_pc = branch_PC_calculation(instr, get_alu_result(fn, rs1, rs2), pc);
            enc_j: begin
                rd_value = pc_plus4;
                rd_write = 1'b1;
                next_pc  = pc + imm;
            end
            enc_i_j: begin
                rd_value = pc_plus4;
                rd_write = 1'b1;
                next_pc  = base_sum & ~32'd1;
            end
            enc_i_l: is_mem = 1'b1;
            enc_s: begin
                is_mem = 1'b1;
                mem_wr = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/iss_sequencer.sv
// Multi-cycle fetch / execute / memory sequencer for the RISC-V ISS core.
//   clk, rst (sync, active high)
//   bus      : imem / dmem request-response handshakes (master side)
//   rs1_addr/rs2_addr -> rs1_data/rs2_data : async register-file reads
//   rd_we/rd_addr/rd_data : register-file write port
//   pc, illegal_instr     : program counter, one-cycle undecodable pulse
//
// state       | meaning
// fetch_ph    | issue fetch at pc, wait for the instruction
// execute_ph  | one cycle: ALU / branch / jump retire, or latch mem request
// mem_req_ph  | hold dmem request until accepted
// mem_done_ph | wait for dmem response, load writeback, pc += 4

module iss_sequencer
    import top_level_types::*;
    import iss_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    iss_sequencer_if.master bus,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [31:0]     rs1_data,
    input  logic [31:0]     rs2_data,
    output logic            rd_we,
    output logic [4:0]      rd_addr,
    output logic [31:0]     rd_data,
    output logic [31:0]     pc,
    output logic            illegal_instr
);
    Phases       phase, phase_nxt;
    logic [31:0] instr_reg;
    logic        fetch_pending, mem_pending;
    logic [31:0] mem_addr_q, mem_data_q;
    logic        mem_wr_q;
    ME_MaskType  mem_mask_q;

    logic [31:0] ex_next_pc, ex_rd_value, ex_mem_addr, ex_mem_data;
    logic        ex_rd_write, ex_mem_wr, ex_is_mem, ex_illegal;
    ME_MaskType  ex_mem_mask;
    logic        fetch_done, mem_done;

    assign rs1_addr = instr_reg[19:15];
    assign rs2_addr = instr_reg[24:20];
    assign rd_addr  = instr_reg[11:7];

    // Responses only count while their request is outstanding.
    assign fetch_done = (phase == fetch_ph) && fetch_pending && bus.imem_resp_valid;
    assign mem_done   = (phase == mem_done_ph) && mem_pending && bus.dmem_resp_valid;

    iss_execute_unit u_exec (
        .instr    (instr_reg),
        .pc       (pc),
        .rs1      (rs1_data),
        .rs2      (rs2_data),
        .next_pc  (ex_next_pc),
        .rd_value (ex_rd_value),
        .rd_write (ex_rd_write),
        .mem_addr (ex_mem_addr),
        .mem_data (ex_mem_data),
        .mem_wr   (ex_mem_wr),
        .mem_mask (ex_mem_mask),
        .is_mem   (ex_is_mem),
        .illegal  (ex_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) phase <= fetch_ph;
        else     phase <= phase_nxt;
    end

    always_comb begin
        phase_nxt = phase;
        case (phase)
            fetch_ph:    if (fetch_done) phase_nxt = execute_ph;
            execute_ph:  phase_nxt = ex_is_mem ? mem_req_ph : fetch_ph;
            mem_req_ph:  if (bus.dmem_req_ready) phase_nxt = mem_done_ph;
            mem_done_ph: if (mem_done) phase_nxt = fetch_ph;
            default:     phase_nxt = fetch_ph;
        endcase
    end

    always_comb begin
        bus.imem_req_valid = 1'b0;
        bus.dmem_req_valid = 1'b0;
        rd_we              = 1'b0;
        rd_data            = ex_rd_value;
        illegal_instr      = 1'b0;
        if (!rst) begin
            case (phase)
                fetch_ph:   bus.imem_req_valid = !fetch_pending;
                execute_ph: begin
                    rd_we         = ex_rd_write && (rd_addr != 5'd0);
                    illegal_instr = ex_illegal;
                end
                mem_req_ph: bus.dmem_req_valid = 1'b1;
                mem_done_ph: begin
                    rd_we   = mem_done && !mem_wr_q && (rd_addr != 5'd0);
                    rd_data = bus.dmem_resp_data;
                end
                default: ;
            endcase
        end
    end

    assign bus.imem_req_addr = pc;
    assign bus.dmem_req_addr = mem_addr_q;
    assign bus.dmem_req_data = mem_data_q;
    assign bus.dmem_req_wr   = mem_wr_q;
    assign bus.dmem_req_mask = mem_mask_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            instr_reg     <= 32'h0;
            fetch_pending <= 1'b0;
            mem_pending   <= 1'b0;
            mem_addr_q    <= 32'h0;
            mem_data_q    <= 32'h0;
            mem_wr_q      <= 1'b0;
            mem_mask_q    <= mt_x;
        end else begin
            case (phase)
                fetch_ph: begin
                    if (bus.imem_req_valid && bus.imem_req_ready) begin
                        fetch_pending <= 1'b1;
                    end else if (fetch_done) begin
                        instr_reg     <= bus.imem_resp_instr;
                        fetch_pending <= 1'b0;
                    end
                end
                execute_ph: begin
                    if (ex_is_mem) begin
                        mem_addr_q <= ex_mem_addr;
                        mem_data_q <= ex_mem_data;
                        mem_wr_q   <= ex_mem_wr;
                        mem_mask_q <= ex_mem_mask;
                    end else begin
                        pc <= ex_next_pc;
                    end
                end
                mem_req_ph: if (bus.dmem_req_ready) mem_pending <= 1'b1;
                mem_done_ph: begin
                    if (mem_done) begin
                        pc          <= pc + 32'd4;
                        mem_pending <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/iss_sequencer.md
# iss_sequencer

Multi-cycle control sequencer for the RISC-V ISS core. It steps one instruction at a time through fetch, execute, memory-request and memory-done phases. It drives the instruction- and data-memory handshakes, the register-file read/write ports and the program counter. Decode and ALU work uses the shared iss_types helpers.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid / imem_req_ready  out / in  1  fetch request handshake.
- imem_req_addr  out  32  fetch address; always equals pc.
- imem_resp_valid / imem_resp_instr  in  1 / 32  fetch response.
- dmem_req_valid / dmem_req_ready  out / in  1  data request handshake.
- dmem_req_addr / dmem_req_data  out  32  effective address / store data.
- dmem_req_wr  out  1  1 = store, 0 = load.
- dmem_req_mask  out  ME_MaskType  access size from get_memory_mask.
- dmem_resp_valid / dmem_resp_data  in  1 / 32  data response; load data arrives already extended.
- rs1_addr / rs2_addr  out  5  register-file read addresses (instr[19:15] / instr[24:20]).
- rs1_data / rs2_data  in  32  asynchronous register-file read data.
- rd_we / rd_addr / rd_data  out  1 / 5 / 32  register-file write port.
- pc  out  32  current program counter.
- illegal_instr  out  1  one-cycle pulse on an undecodable instruction.

## Operation
- State is phase (Phases enum), plus pc, instr_reg, fetch_pending and mem_pending.
- Reset:
  - phase = fetch_ph, pc = RESET_PC, instr_reg = 0, both pending flags = 0.
  - While rst is high, all valids, rd_we and illegal_instr are forced to 0.
- fetch_ph:
  - imem_req_valid = !fetch_pending.
  - Acceptance (valid & ready) sets fetch_pending.
  - While pending, imem_resp_valid latches instr_reg, clears fetch_pending and moves to execute_ph.
- execute_ph (exactly one cycle). Behaviour by get_enc_type(instr_reg):
  - enc_r: rd = alu(rs1, rs2); pc += 4.
  - enc_i_i: rd = alu(rs1, imm); pc += 4.
  - enc_u: rd = get_Enc_U_ALU_result; pc += 4.
  - enc_b: pc = branch_PC_calculation(instr, alu(rs1, rs2), pc); no write.
  - enc_j: rd = pc+4; pc += imm.
  - enc_i_j: rd = pc+4; pc = (rs1+imm) & ~1.
  - enc_i_l / enc_s: latch addr = rs1+imm, data = rs2, wr and mask; go to mem_req_ph.
  - enc_err or instr_unknown: illegal_instr = 1; no write; pc += 4.
  - Every case except load/store returns to fetch_ph.
- mem_req_ph:
  - dmem_req_valid = 1, with addr/data/wr/mask held stable until dmem_req_ready.
  - On acceptance: set mem_pending, go to mem_done_ph.
- mem_done_ph:
  - Wait for dmem_resp_valid; stores are acknowledged too.
  - Loads write rd = dmem_resp_data.
  - Then pc += 4, clear mem_pending, go to fetch_ph.
- Register writes:
  - rd_we = 1 only in the write cycle, and only when rd_addr != 0.
  - rd_addr = instr_reg[11:7].
- Arithmetic is 32-bit modulo; pc wraps from 0xFFFF_FFFC to 0.
- Response valids arriving with no matching pending flag are ignored. Memories share rst, so no stale responses survive a reset.
- rst asserted in any phase (including mid-handshake) aborts the instruction. No register write occurs, and the next cycle is the reset state.

## Timing
- Request valids, rd_we, rd_data and illegal_instr are combinational from registered state and response inputs. The register file samples rd on the same edge.
- Responses come no earlier than the cycle after request acceptance.
- Minimum latency with ready=1 and responses one cycle after acceptance:
  - ALU, branch and jump: 3 cycles (fetch accept, fetch response, execute).
  - Load/store: 5 cycles.
- Back-pressure: valid stays high and payload stays unchanged for every cycle that ready is low.
- pc updates on the edge that leaves execute_ph (non-memory) or mem_done_ph.

## Structure
- Phases, opcodes and the helpers get_enc_type, get_instr_type, get_alu_funct, get_alu_result, get_immediate, get_memory_mask, branch_PC_calculation and get_Enc_U_ALU_result live in package iss_types.
- EncType, InstrType, ALUfuncType and ME_MaskType live in top_level_types.
- One combinational sub-module, iss_execute_unit:
  - Inputs: instr, pc, rs1, rs2.
  - Outputs: next_pc, rd_value, rd_write, mem_addr, mem_data, mem_wr, mem_mask, is_mem, illegal.
- The sequencer FSM and all registers stay in iss_sequencer.

## Test plan
- Reset, then 0x00500093 (addi x1,x0,5) -> imem_req_addr 0 one cycle after reset release; rd_we with rd_addr 1, rd_data 5; pc 0x4.
- 0x002081B3 (add x3,x1,x2) with rs1 5, rs2 7 -> rd_addr 3, rd_data 12. Repeat with rd = x0 -> rd_we stays 0.
- 0x0080A283 (lw x5,8(x1)) with rs1 0x100 and dmem_req_ready low 3 cycles:
  - dmem_req_valid stays high with addr 0x108, wr 0, mask mt_w, all stable.
  - Response 0xDEADBEEF -> rd 5 = 0xDEADBEEF; pc += 4.
- 0x00208863 (beq x1,x2,+16) at pc 0x20 -> pc 0x30 when rs1 == rs2, pc 0x24 otherwise; no rd_we.
- 0x008000EF (jal x1,+8) at pc 0x40 -> rd 1 = 0x44, pc 0x48. Then 0xFFFFFFFF -> illegal_instr pulse, no rd_we, pc 0x4C.
- rst during mem_req_ph with ready low -> next cycle dmem_req_valid 0, pc = RESET_PC, fetch restarts.
